// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt scheduler.
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SERV = 2'd2
  } irq_state_t;

  localparam logic [31:0] MCAUSE_INT = 32'h8000_0000;
  localparam int          ID_W       = 5;

endpackage

// File: rtl/irq_prio_sel.sv
// Rotating priority selector: rotates the candidate vector so that index ptr_i
// sits at bit 0, picks the lowest set bit, and maps it back to a source index.
// With ptr_i tied to zero it degenerates to a fixed lowest-index-wins encoder.
module irq_prio_sel
  import irq_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0]    cand_i,
  input  logic [ID_W-1:0] ptr_i,
  output logic            valid_o,
  output logic [ID_W-1:0] idx_o
);

  logic [2*N-1:0]  dbl;
  logic [N-1:0]    rot;
  logic [ID_W-1:0] pos;
  logic [ID_W:0]   sum;

  // Rotate, encode lowest set bit, then un-rotate modulo N.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path can infer a latch.
    dbl = {cand_i, cand_i};
    rot = '0;
    pos = '0;
    for (int j = 0; j < N; j++) begin
      rot[j] = dbl[j + int'(ptr_i)];
    end
    for (int j = N - 1; j >= 0; j--) begin
      if (rot[j]) pos = ID_W'(j);
    end
    valid_o = |rot;
    sum     = {1'b0, pos} + {1'b0, ptr_i};
    if (sum >= (ID_W + 1)'(N)) sum = sum - (ID_W + 1)'(N);
    idx_o = sum[ID_W-1:0];
  end

endmodule

// File: rtl/irq_scheduler.sv
// Interrupt scheduler: captures edge/level requests, arbitrates among enabled
// pending sources and presents one request at a time until the handler returns.
module irq_scheduler
  import irq_pkg::*;
#(
  parameter int          N_SRC     = 32,
  parameter logic [31:0] EDGE_MASK = 32'hFFFF_FFFF,
  parameter logic        RR_EN     = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [N_SRC-1:0] irq_src_i,
  input  logic [N_SRC-1:0] mie_i,
  input  logic             take_i,
  input  logic             mret_i,
  output logic             irq_o,
  output logic [ID_W-1:0]  irq_id_o,
  output logic [31:0]      mcause_o,
  output logic [N_SRC-1:0] pending_o
);

  logic [N_SRC-1:0] pending_q, pending_d;
  logic [N_SRC-1:0] prev_q, prev_d;
  irq_state_t       state_q, state_d;
  logic             irq_q, irq_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;

  logic [N_SRC-1:0] cand;
  logic [ID_W-1:0]  sel_ptr;
  logic             sel_valid;
  logic [ID_W-1:0]  sel_idx;
  logic             take_ok;

  assign take_ok = take_i && (state_q == REQ);
  assign cand    = pending_q & mie_i;
  assign sel_ptr = RR_EN ? rr_ptr_q : '0;

  irq_prio_sel #(.N(N_SRC)) u_sel (
    .cand_i  (cand),
    .ptr_i   (sel_ptr),
    .valid_o (sel_valid),
    .idx_o   (sel_idx)
  );

  // Capture: edge sources latch rising edges until taken (a new edge beats the
  // clear), level sources simply follow the line. Masking does not affect capture.
  always_comb begin
    prev_d    = irq_src_i;
    pending_d = pending_q;
    for (int i = 0; i < N_SRC; i++) begin
      pending_d[i] = EDGE_MASK[i]
        ? ((irq_src_i[i] && !prev_q[i]) ||
           (pending_q[i] && !(take_ok && (id_q == ID_W'(i)))))
        : irq_src_i[i];
    end
  end

  // Next-state for the presentation FSM, its registered request and the RR pointer.
  always_comb begin
    state_d  = state_q;
    irq_d    = irq_q;
    id_d     = id_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (sel_valid) begin
          state_d = REQ;
          irq_d   = 1'b1;
          id_d    = sel_idx;
        end
      end
      REQ: begin
        // Take has priority over a coincident mret; mret alone is ignored here.
        if (take_i) begin
          state_d  = SERV;
          irq_d    = 1'b0;
          rr_ptr_d = (id_q == ID_W'(N_SRC - 1)) ? '0 : id_q + ID_W'(1);
        end
      end
      SERV: begin
        if (mret_i) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        irq_d   = 1'b0;
      end
    endcase
  end

  // All state registers; reset drops any pending events.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q <= '0;
      prev_q    <= '0;
      state_q   <= IDLE;
      irq_q     <= 1'b0;
      id_q      <= '0;
      rr_ptr_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      pending_q <= pending_d;
      prev_q    <= prev_d;
      state_q   <= state_d;
      irq_q     <= irq_d;
      id_q      <= id_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

  assign irq_o     = irq_q;
  assign irq_id_o  = id_q;
  assign mcause_o  = MCAUSE_INT | {27'b0, id_q};
  assign pending_o = pending_q;

endmodule

// File: tb/tb_irq_scheduler.sv
// Directed bench: one fixed-priority all-edge instance and one round-robin
// instance with level sources 0 and 5.
module tb_irq_scheduler;
  import irq_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] src1 = '0, mie1 = '1;
  logic        take1 = 1'b0, mret1 = 1'b0;
  logic        irq1;
  logic [4:0]  id1;
  logic [31:0] mc1, pend1;

  logic [31:0] src2 = '0, mie2 = '1;
  logic        take2 = 1'b0, mret2 = 1'b0;
  logic        irq2;
  logic [4:0]  id2;
  logic [31:0] mc2, pend2;

  int tests = 0;
  int fails = 0;

  irq_scheduler #(.N_SRC(32), .EDGE_MASK(32'hFFFF_FFFF), .RR_EN(1'b0)) u_fix (
    .clk_i(clk), .rst_ni(rst_n), .irq_src_i(src1), .mie_i(mie1),
    .take_i(take1), .mret_i(mret1), .irq_o(irq1), .irq_id_o(id1),
    .mcause_o(mc1), .pending_o(pend1)
  );

  irq_scheduler #(.N_SRC(32), .EDGE_MASK(32'hFFFF_FFDE), .RR_EN(1'b1)) u_rr (
    .clk_i(clk), .rst_ni(rst_n), .irq_src_i(src2), .mie_i(mie2),
    .take_i(take2), .mret_i(mret2), .irq_o(irq2), .irq_id_o(id2),
    .mcause_o(mc2), .pending_o(pend2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset values
    #2;
    check("rst_irq", 32'(irq1), 32'd0);
    check("rst_id", 32'(id1), 32'd0);
    check("rst_mcause", mc1, 32'h8000_0000);
    check("rst_pend", pend1, 32'd0);
    check("rst_rr_irq", 32'(irq2), 32'd0);
    step(); step();
    rst_n = 1'b1;
    step();

    // 1. Edge on source 9
    src1[9] = 1'b1;
    step();
    check("t1_pend9", 32'(pend1[9]), 32'd1);
    check("t1_irq_early", 32'(irq1), 32'd0);
    step();
    check("t1_irq", 32'(irq1), 32'd1);
    check("t1_id", 32'(id1), 32'd9);
    check("t1_mcause", mc1, 32'h8000_0009);
    mret1 = 1'b1; step(); mret1 = 1'b0;
    check("t1_mret_in_req", 32'(irq1), 32'd1);
    take1 = 1'b1; step(); take1 = 1'b0;
    check("t1_take_irq", 32'(irq1), 32'd0);
    check("t1_take_pend9", 32'(pend1[9]), 32'd0);
    step();
    check("t1_serv_irq", 32'(irq1), 32'd0);
    mret1 = 1'b1; step(); mret1 = 1'b0;
    src1[9] = 1'b0;
    step();
    check("t1_idle_irq", 32'(irq1), 32'd0);

    // 2. Sources 3 and 13 together, fixed priority
    src1[3] = 1'b1; src1[13] = 1'b1;
    step(); step();
    check("t2_irq", 32'(irq1), 32'd1);
    check("t2_id3", 32'(id1), 32'd3);
    take1 = 1'b1; step(); take1 = 1'b0;
    check("t2_pend13", pend1, 32'h0000_2000);
    mret1 = 1'b1; step(); mret1 = 1'b0;
    check("t2_gap", 32'(irq1), 32'd0);
    step();
    check("t2_irq13", 32'(irq1), 32'd1);
    check("t2_id13", 32'(id1), 32'd13);
    check("t2_mcause13", mc1, 32'h8000_000D);
    take1 = 1'b1; step(); take1 = 1'b0;
    mret1 = 1'b1; step(); mret1 = 1'b0;
    src1[3] = 1'b0; src1[13] = 1'b0;
    step();
    check("t2_done", 32'(irq1), 32'd0);

    // 3. Round-robin with level sources 0 and 5
    src2[0] = 1'b1; src2[5] = 1'b1;
    step();
    check("t3_pend", pend2, 32'h0000_0021);
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4 && !irq2; c++) step();
      check($sformatf("t3_irq_r%0d", r), 32'(irq2), 32'd1);
      check($sformatf("t3_id_r%0d", r), 32'(id2), (r % 2) ? 32'd5 : 32'd0);
      take2 = 1'b1; step(); take2 = 1'b0;
      mret2 = 1'b1; step(); mret2 = 1'b0;
    end
    src2 = '0;

    // 4. Masking
    mie1 = ~32'h0000_0080;
    src1[7] = 1'b1; step(); src1[7] = 1'b0;
    check("t4_pend7", 32'(pend1[7]), 32'd1);
    check("t4_masked", 32'(irq1), 32'd0);
    step(); step();
    check("t4_still_masked", 32'(irq1), 32'd0);
    check("t4_still_pend7", 32'(pend1[7]), 32'd1);
    mie1 = '1;
    for (int c = 0; c < 2 && !irq1; c++) step();
    check("t4_unmask_irq", 32'(irq1), 32'd1);
    check("t4_id7", 32'(id1), 32'd7);
    take1 = 1'b1; step(); take1 = 1'b0;
    check("t4_clear7", 32'(pend1[7]), 32'd0);
    mret1 = 1'b1; step(); mret1 = 1'b0;
    step();

    // 5. New edge on 9 in the take cycle
    src1[9] = 1'b1; step(); step();
    check("t5_id9", 32'(id1), 32'd9);
    src1[9] = 1'b0; step();
    src1[9] = 1'b1; take1 = 1'b1; step(); take1 = 1'b0;
    check("t5_set_wins", 32'(pend1[9]), 32'd1);
    check("t5_serv", 32'(irq1), 32'd0);
    mret1 = 1'b1; step(); mret1 = 1'b0;
    check("t5_gap", 32'(irq1), 32'd0);
    step();
    check("t5_repres", 32'(irq1), 32'd1);
    check("t5_repres_id", 32'(id1), 32'd9);
    take1 = 1'b1; step(); take1 = 1'b0;
    check("t5_clear9", 32'(pend1[9]), 32'd0);
    mret1 = 1'b1; step(); mret1 = 1'b0;
    src1[9] = 1'b0; step();

    // 6. take+mret together, then reset mid-service
    src1[3] = 1'b1; src1[13] = 1'b1; step(); step();
    check("t6_id3", 32'(id1), 32'd3);
    take1 = 1'b1; mret1 = 1'b1; step(); take1 = 1'b0; mret1 = 1'b0;
    check("t6_take_wins", 32'(irq1), 32'd0);
    check("t6_pend13", pend1, 32'h0000_2000);
    step(); step();
    check("t6_stay_serv", 32'(irq1), 32'd0);
    rst_n = 1'b0; #2;
    check("t6_rst_irq", 32'(irq1), 32'd0);
    check("t6_rst_id", 32'(id1), 32'd0);
    check("t6_rst_mcause", mc1, 32'h8000_0000);
    check("t6_rst_pend", pend1, 32'd0);
    src1 = '0;
    step();
    rst_n = 1'b1;
    step(); step(); step();
    check("t6_quiet_irq", 32'(irq1), 32'd0);
    check("t6_quiet_pend", pend1, 32'd0);
    src1[13] = 1'b1; step(); step();
    check("t6_new_irq", 32'(irq1), 32'd1);
    check("t6_new_id", 32'(id1), 32'd13);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
